// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the 8-to-3 event encoder.
package encoder_pkg;

  localparam int EV_W       = 8;
  localparam int ADDR_W     = 3;
  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  function automatic logic [EV_W-1:0] onehot3(input logic [ADDR_W-1:0] idx);
    return EV_W'(1) << idx;
  endfunction

  function automatic logic [3:0] popcount8(input logic [EV_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < EV_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prio_select8.sv
// Combinational picker: lowest set bit (fixed) or first set bit at/after start (round-robin).
module prio_select8
  import encoder_pkg::*;
(
  input  logic [EV_W-1:0]   cand,
  input  logic [ADDR_W-1:0] start,
  input  logic              mode,
  output logic [ADDR_W-1:0] sel,
  output logic              any
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] idx;
  logic              found;

  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    any   = |cand;
    base  = mode ? start : '0;
    // Index arithmetic is 3 bits wide, so the scan wraps from 7 back to 0.
    for (int i = 0; i < EV_W; i++) begin
      idx = base + ADDR_W'(i);
      if (!found && cand[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder_8to3.sv
// Captures event pulses into a pending set and offers one encoded index per cycle
// over valid/ready; repeats of an outstanding index are counted as drops.
module event_encoder_8to3
  import encoder_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [EV_W-1:0]   pattern_in,
  output logic [ADDR_W-1:0] address_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [EV_W-1:0]   pending_out,
  output logic              drop_flag,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_drop
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [3:0]       inc);
    logic [CNT_W+3:0] sum;
    sum = (CNT_W+4)'(base) + (CNT_W+4)'(inc);
    if (|sum[CNT_W+3:CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [EV_W-1:0]   pending_p1;
  logic [ADDR_W-1:0] rr_ptr;
  logic              drop_flag_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  logic              acc;
  logic              load;
  logic [EV_W-1:0]   held;
  logic [EV_W-1:0]   blocked;
  logic [EV_W-1:0]   drop_vec;
  logic [EV_W-1:0]   cand;
  logic [ADDR_W-1:0] sel;
  logic              sel_any;

  // Stage p0: classify arrivals against what is already pending or on offer
  always_comb begin
    acc      = vld_p1 & ready_in;
    load     = ~vld_p1 | acc;
    held     = (vld_p1 & ~acc) ? onehot3(addr_p1) : '0;
    blocked  = pending_p1 | held;
    drop_vec = pattern_in & blocked;
    cand     = pending_p1 | (pattern_in & ~held);
  end

  prio_select8 u_sel (
    .cand  (cand),
    .start (rr_ptr),
    .mode  (PRIO_MODE == PRIO_RR),
    .sel   (sel),
    .any   (sel_any)
  );

  // Stage p1: offer register, pending set and drop status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
      pending_p1  <= '0;
      rr_ptr      <= '0;
      drop_flag_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      if (load) begin
        if (sel_any) begin
          vld_p1     <= 1'b1;
          addr_p1    <= sel;
          pending_p1 <= cand & ~onehot3(sel);
          rr_ptr     <= sel + ADDR_W'(1);
        end else begin
          vld_p1     <= 1'b0;
          addr_p1    <= '0;
          pending_p1 <= '0;
        end
      end else begin
        pending_p1 <= cand;
      end
      // A drop in the same cycle as a clear restarts the count from this cycle's drops.
      drop_cnt_q  <= sat_add(clr_drop ? '0 : drop_cnt_q, popcount8(drop_vec));
      drop_flag_q <= (drop_flag_q & ~clr_drop) | (|drop_vec);
    end
  end

  assign address_out = addr_p1;
  assign valid_out   = vld_p1;
  assign pending_out = pending_p1;
  assign drop_flag   = drop_flag_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Bench for event_encoder_8to3: fixed-priority and round-robin instances driven in
// parallel, checked against an index-level model plus directed expectations.
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pattern_in = 8'h00;
  logic       ready_in = 1'b1;
  logic       clr_drop = 1'b0;

  logic [2:0] addr_f, addr_r;
  logic       valid_f, valid_r;
  logic [7:0] pend_f, pend_r;
  logic       flag_f, flag_r;
  logic [7:0] cnt_f, cnt_r;

  int n_pass  = 0;
  int n_total = 0;

  // model state, index 0 = fixed priority, 1 = round-robin
  bit m_valid[2];
  int m_addr[2];
  bit m_pend[2][8];
  int m_ptr[2];
  int m_cnt[2];
  bit m_flag[2];

  always #5 clk = ~clk;

  event_encoder_8to3 #(.PRIO_MODE(0), .CNT_W(8)) u_fixed (
    .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .address_out(addr_f),
    .valid_out(valid_f), .ready_in(ready_in), .pending_out(pend_f),
    .drop_flag(flag_f), .drop_cnt(cnt_f), .clr_drop(clr_drop)
  );

  event_encoder_8to3 #(.PRIO_MODE(1), .CNT_W(8)) u_rr (
    .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .address_out(addr_r),
    .valid_out(valid_r), .ready_in(ready_in), .pending_out(pend_r),
    .drop_flag(flag_r), .drop_cnt(cnt_r), .clr_drop(clr_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_pend(input int i);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < 8; k++) if (m_pend[i][k]) v = v + (32'd1 << k);
    return v;
  endfunction

  task automatic model_step(input int i, input logic [7:0] pat, input logic rdy,
                            input logic clr, input logic rstn);
    bit nxt[8];
    bit accepted;
    bit found;
    int drops;
    int base;
    int idx;
    if (!rstn) begin
      m_valid[i] = 0; m_addr[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0; m_flag[i] = 0;
      for (int k = 0; k < 8; k++) m_pend[i][k] = 0;
      return;
    end
    accepted = m_valid[i] && rdy;
    drops = 0;
    for (int k = 0; k < 8; k++) begin
      nxt[k] = m_pend[i][k];
      if (pat[k]) begin
        if (m_pend[i][k] || (m_valid[i] && !accepted && m_addr[i] == k)) drops++;
        else nxt[k] = 1;
      end
    end
    if (!m_valid[i] || accepted) begin
      found = 0;
      for (int j = 0; j < 8; j++) begin
        idx = (i == 1) ? (m_ptr[i] + j) % 8 : j;
        if (!found && nxt[idx]) begin
          found = 1;
          m_addr[i] = idx;
        end
      end
      if (found) begin
        m_valid[i] = 1;
        nxt[m_addr[i]] = 0;
        m_ptr[i] = (m_addr[i] + 1) % 8;
      end else begin
        m_valid[i] = 0;
        m_addr[i] = 0;
      end
    end
    for (int k = 0; k < 8; k++) m_pend[i][k] = nxt[k];
    base = clr ? 0 : m_cnt[i];
    m_cnt[i] = (base + drops > 255) ? 255 : base + drops;
    m_flag[i] = (clr ? 1'b0 : m_flag[i]) || (drops > 0);
  endtask

  task automatic compare_all();
    check("fixed.valid", 32'(valid_f), 32'(m_valid[0]));
    check("fixed.addr",  32'(addr_f),  32'(m_addr[0]));
    check("fixed.pend",  32'(pend_f),  model_pend(0));
    check("fixed.flag",  32'(flag_f),  32'(m_flag[0]));
    check("fixed.cnt",   32'(cnt_f),   32'(m_cnt[0]));
    check("rr.valid",    32'(valid_r), 32'(m_valid[1]));
    check("rr.addr",     32'(addr_r),  32'(m_addr[1]));
    check("rr.pend",     32'(pend_r),  model_pend(1));
    check("rr.flag",     32'(flag_r),  32'(m_flag[1]));
    check("rr.cnt",      32'(cnt_r),   32'(m_cnt[1]));
  endtask

  task automatic cycle(input logic [7:0] pat, input logic rdy, input logic clr, input logic rstn);
    @(negedge clk);
    pattern_in = pat;
    ready_in   = rdy;
    clr_drop   = clr;
    rst_n      = rstn;
    model_step(0, pat, rdy, clr, rstn);
    model_step(1, pat, rdy, clr, rstn);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int exp_f[4];
    int exp_r[4];
    logic [7:0] pat;
    exp_f = '{0, 2, 5, 7};
    exp_r = '{5, 7, 0, 2};

    // reset state
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    check("reset.valid", 32'(valid_f), 32'd0);
    check("reset.cnt",   32'(cnt_f),   32'd0);

    // single pulse, one-cycle latency
    cycle(8'h10, 1'b1, 1'b0, 1'b1);
    check("single.valid", 32'(valid_f), 32'd1);
    check("single.addr",  32'(addr_f),  32'd4);
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    check("single.idle_valid", 32'(valid_f), 32'd0);
    check("single.idle_addr",  32'(addr_f),  32'd0);

    // grant index 2 so the round-robin pointer sits at 3, then burst A5
    cycle(8'h04, 1'b1, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      cycle(n == 0 ? 8'hA5 : 8'h00, 1'b1, 1'b0, 1'b1);
      check("burst.fixed_addr", 32'(addr_f), 32'(exp_f[n]));
      check("burst.rr_addr",    32'(addr_r), 32'(exp_r[n]));
    end
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    check("burst.idle", 32'(valid_f), 32'd0);
    check("burst.cnt",  32'(cnt_f),   32'd0);

    // stall: repeat of offered index drops, new index pends
    cycle(8'h01, 1'b0, 1'b0, 1'b1);
    cycle(8'h01, 1'b0, 1'b0, 1'b1);
    cycle(8'h02, 1'b0, 1'b0, 1'b1);
    check("stall.addr", 32'(addr_f), 32'd0);
    check("stall.cnt",  32'(cnt_f),  32'd1);
    check("stall.flag", 32'(flag_f), 32'd1);
    check("stall.pend", 32'(pend_f), 32'h02);
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    check("stall.next_addr", 32'(addr_f), 32'd1);
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1, 1'b1);
    check("clear.cnt",  32'(cnt_f),  32'd0);
    check("clear.flag", 32'(flag_f), 32'd0);

    // same index arriving on its accept cycle is a fresh event
    cycle(8'h08, 1'b0, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    cycle(8'h08, 1'b1, 1'b0, 1'b1);
    check("reissue.valid", 32'(valid_f), 32'd1);
    check("reissue.addr",  32'(addr_f),  32'd3);
    check("reissue.cnt",   32'(cnt_f),   32'd0);
    cycle(8'h00, 1'b1, 1'b0, 1'b1);

    // reset mid-offer discards everything
    cycle(8'hF1, 1'b0, 1'b0, 1'b1);
    check("midrst.pend_before", 32'(pend_f), 32'hF0);
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
    check("midrst.valid", 32'(valid_f), 32'd0);
    check("midrst.pend",  32'(pend_f),  32'd0);
    check("midrst.rr_valid", 32'(valid_r), 32'd0);
    cycle(8'h00, 1'b0, 1'b0, 1'b1);

    // clear coinciding with a two-event drop restarts the count
    cycle(8'h03, 1'b0, 1'b0, 1'b1);
    cycle(8'h03, 1'b0, 1'b0, 1'b1);
    cycle(8'h03, 1'b0, 1'b1, 1'b1);
    check("clrdrop.cnt",  32'(cnt_f),  32'd2);
    check("clrdrop.flag", 32'(flag_f), 32'd1);
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b0, 1'b1);

    // eight simultaneous events drain back-to-back
    for (int n = 0; n < 8; n++) begin
      cycle(n == 0 ? 8'hFF : 8'h00, 1'b1, 1'b0, 1'b1);
      check("drain.valid", 32'(valid_f), 32'd1);
      check("drain.addr",  32'(addr_f),  32'(n));
    end
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    check("drain.idle", 32'(valid_f), 32'd0);

    // drop counter saturation under a long stall
    for (int n = 0; n < 40; n++) cycle(8'hFF, 1'b0, 1'b0, 1'b1);
    check("sat.fixed_cnt", 32'(cnt_f), 32'd255);
    check("sat.rr_cnt",    32'(cnt_r), 32'd255);
    cycle(8'h00, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 9; n++) cycle(8'h00, 1'b1, 1'b0, 1'b1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      pat = 8'($urandom & $urandom);
      cycle(pat, ($urandom % 4) != 0, ($urandom % 32) == 0, ($urandom % 128) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
